alu_share_arbiter: RTL and testbench

//  Shares the single ALU between two requesters: port 0 = CPU core, port 1 = debug/monitor (UART).

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_rr_arb2.sv | 23 ++
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes, legality check, FSM states.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Imported by alu_share_arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_SLL = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_t;

    function automatic logic alu_ctl_legal(input logic [3:0] ctl);
        case (ctl)
            ALU_CTL_AND, ALU_CTL_OR, ALU_CTL_ADD,
            ALU_CTL_SUB, ALU_CTL_SLT, ALU_CTL_SLL: alu_ctl_legal = 1'b1;
            default:                               alu_ctl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-port round-robin grant: a lone valid port wins, on contention the port other than rr_last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: grant is all-zero while enable is low.
module alu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between CPU (port 0) and debug (port 1), round-robin; ALU_ARB_PERF_EN adds perf counters.
// Latency: transfer at cycle T gives a one-cycle rspN_valid pulse at T+ALU_LAT+1.
// Backpressure: both ready lines stay low while an op executes; responses cannot be stalled.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_ctl,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_ctl,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_zero,
    output logic          rsp_err,
    output logic [3:0]    alu_ctl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]   perf_gnt0,
    output logic [15:0]   perf_gnt1,
    output logic [15:0]   perf_conflict
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [1:0]    grant;
    logic          xfer;
    logic          done;
    logic          rr_last;
    logic          owner_q;
    logic [3:0]    cnt;
    logic [3:0]    ctl_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          legal;

    alu_rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .enable  (state == IDLE),
        .grant   (grant)
    );

    assign xfer  = |grant;
    assign done  = (state == EXEC) && (cnt == 4'd0);
    assign legal = alu_ctl_legal(ctl_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Park the ALU on ADD with zero operands when idle so it never sees stale data.
    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        alu_ctl    = ALU_CTL_ADD;
        alu_a      = '0;
        alu_b      = '0;
        if (state == EXEC) begin
            alu_ctl = ctl_q;
            alu_a   = a_q;
            alu_b   = b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            owner_q <= 1'b0;
            cnt     <= 4'd0;
            ctl_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (xfer) begin
            rr_last <= grant[1];
            owner_q <= grant[1];
            cnt     <= CNT_INIT;
            ctl_q   <= grant[1] ? req1_ctl : req0_ctl;
            a_q     <= grant[1] ? req1_a   : req0_a;
            b_q     <= grant[1] ? req1_b   : req0_b;
        end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp0_valid <= done && !owner_q;
            rsp1_valid <= done &&  owner_q;
            if (done) begin
                rsp_result <= legal ? alu_y    : '0;
                rsp_zero   <= legal ? alu_zero : 1'b1;
                rsp_err    <= !legal;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0     <= 16'd0;
            perf_gnt1     <= 16'd0;
            perf_conflict <= 16'd0;
        end else begin
            if (grant[0] && perf_gnt0 != 16'hFFFF) perf_gnt0 <= perf_gnt0 + 16'd1;
            if (grant[1] && perf_gnt1 != 16'hFFFF) perf_gnt1 <= perf_gnt1 + 16'd1;
            if (state == IDLE && req0_valid && req1_valid && perf_conflict != 16'hFFFF)
                perf_conflict <= perf_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: three instances with ALU_LAT = 1, 3, 4 and a queue scoreboard.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [3];
    logic [1:0]  vld  [3];
    logic [3:0]  rctl [3][2];
    logic [31:0] ra   [3][2];
    logic [31:0] rb   [3][2];

    wire  [1:0]  rdy  [3];
    wire  [1:0]  rspv [3];
    wire  [31:0] res  [3];
    wire         zf   [3];
    wire         ef   [3];
    wire  [3:0]  actl [3];
    wire  [31:0] aa   [3];
    wire  [31:0] ab   [3];
    wire  [31:0] ay   [3];
    wire         az   [3];
`ifdef ALU_ARB_PERF_EN
    wire  [15:0] pg0  [3];
    wire  [15:0] pg1  [3];
    wire  [15:0] pcf  [3];
`endif

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0000: alu_model = x & y;
            4'b0001: alu_model = x | y;
            4'b0010: alu_model = x + y;
            4'b0110: alu_model = x - y;
            4'b0111: alu_model = {31'd0, $signed(x) < $signed(y)};
            4'b1111: alu_model = x << y[4:0];
            default: alu_model = 32'hDEADBEEF;
        endcase
    endfunction

    function automatic int lat(input int k);
        lat = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_share_arbiter #(.DW(32), .ALU_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
            .clk        (clk),
            .rst_n      (rstn[g]),
            .req0_valid (vld[g][0]),
            .req0_ready (rdy[g][0]),
            .req0_ctl   (rctl[g][0]),
            .req0_a     (ra[g][0]),
            .req0_b     (rb[g][0]),
            .req1_valid (vld[g][1]),
            .req1_ready (rdy[g][1]),
            .req1_ctl   (rctl[g][1]),
            .req1_a     (ra[g][1]),
            .req1_b     (rb[g][1]),
            .rsp0_valid (rspv[g][0]),
            .rsp1_valid (rspv[g][1]),
            .rsp_result (res[g]),
            .rsp_zero   (zf[g]),
            .rsp_err    (ef[g]),
            .alu_ctl    (actl[g]),
            .alu_a      (aa[g]),
            .alu_b      (ab[g]),
            .alu_y      (ay[g]),
            .alu_zero   (az[g])
`ifdef ALU_ARB_PERF_EN
            ,
            .perf_gnt0     (pg0[g]),
            .perf_gnt1     (pg1[g]),
            .perf_conflict (pcf[g])
`endif
        );
        assign ay[g] = alu_model(actl[g], aa[g], ab[g]);
        assign az[g] = (ay[g] == 32'd0);
    end

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] result;
        logic        zero;
        logic        err;
        int          due;
    } sb_t;

    sb_t         sbq [$];
    logic [31:0] eres [3][2];
    logic        ez   [3][2];
    logic        ee   [3][2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push on every observed transfer, pop and compare on every response pulse.
    always @(negedge clk) begin : mon
        sb_t e;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (rstn[k] && vld[k][p] && rdy[k][p]) begin
                    e.inst = k; e.port = p; e.result = eres[k][p];
                    e.zero = ez[k][p]; e.err = ee[k][p]; e.due = cyc + lat(k) + 1;
                    sbq.push_back(e);
                end
            end
            if (rdy[k] != 2'b00)
                chk($sformatf("ready_onehot_i%0d", k), {62'd0, rdy[k]} & {62'd0, rdy[k] - 2'b01}, 64'd0);
            if (rspv[k] != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_rsp_i%0d", k), {62'd0, rspv[k]}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_inst",   k,               e.inst);
                    chk("rsp_port",   {62'd0, rspv[k]}, (e.port == 0) ? 64'd1 : 64'd2);
                    chk("rsp_result", res[k],          e.result);
                    chk("rsp_zero",   zf[k],           e.zero);
                    chk("rsp_err",    ef[k],           e.err);
                    chk("rsp_cycle",  cyc,             e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int p, input logic [3:0] c, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] er, input logic z, input logic e);
        rctl[k][p] = c; ra[k][p] = x; rb[k][p] = y;
        eres[k][p] = er; ez[k][p] = z; ee[k][p] = e;
        vld[k][p]  = 1'b1;
    endtask

    // Returns just after the clock edge that completes the transfer; t is the transfer cycle.
    task automatic wait_xfer(input int k, input int p, output int t);
        bit got = 1'b0;
        t = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rdy[k][p]) begin got = 1'b1; t = cyc; end
        end
        chk($sformatf("xfer_i%0d_p%0d", k, p), {63'd0, got}, 64'd1);
        tick();
    endtask

    task automatic chk_idle_outputs(input int k, input string tag);
        chk({tag, "_alu_ctl"}, actl[k], 64'h2);
        chk({tag, "_alu_a"},   aa[k],   64'd0);
        chk({tag, "_alu_b"},   ab[k],   64'd0);
    endtask

    initial begin
        int  t;
        bit  got;

        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0;
            vld[k]  = 2'b00;
            for (int p = 0; p < 2; p++) begin
                rctl[k][p] = 4'd0; ra[k][p] = 32'd0; rb[k][p] = 32'd0;
                eres[k][p] = 32'd0; ez[k][p] = 1'b0; ee[k][p] = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_idle_outputs(k, "reset");
            chk("reset_result", res[k],  64'd0);
            chk("reset_zero",   zf[k],   64'd0);
            chk("reset_err",    ef[k],   64'd0);
            chk("reset_rspv",   rspv[k], 64'd0);
            chk("reset_ready",  rdy[k],  64'd0);
        end

        // Contention from reset: both ports SUB 3-3, held valid for 4 back-to-back pairs.
        set_req(0, 0, 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        set_req(0, 1, 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (rdy[0] != 2'b00) begin
                    got = 1'b1;
                    chk($sformatf("rr_order_%0d", n), rdy[0], (n % 2 == 0) ? 64'd1 : 64'd2);
                end
            end
            chk("rr_xfer", {63'd0, got}, 64'd1);
            tick();
        end
        vld[0] = 2'b00;
        repeat (4) tick();

        // Single ADD on port 0, ALU_LAT=1, then check the result holds.
        set_req(0, 0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        wait_xfer(0, 0, t);
        vld[0][0] = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("hold_result", res[0],  64'd12);
        chk("hold_zero",   zf[0],   64'd0);
        chk("hold_rspv",   rspv[0], 64'd0);
        tick();

        // Illegal control code: result forced to 0, err and zero set.
        set_req(0, 0, 4'b1010, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
        wait_xfer(0, 0, t);
        vld[0][0] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_idle_outputs(0, "after_illegal");
        chk("hold_err", ef[0], 64'd1);
        tick();

        // ALU_LAT=3: SLT -1<1 on port 1, port 0 waits through EXEC and is taken with the pulse.
        set_req(1, 1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        wait_xfer(1, 1, t);
        vld[1][1] = 1'b0;
        set_req(1, 0, 4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("exec_ctl_%0d", i),   actl[1],   64'h7);
            chk($sformatf("exec_a_%0d", i),     aa[1],     64'hFFFF_FFFF);
            chk($sformatf("exec_b_%0d", i),     ab[1],     64'd1);
            chk($sformatf("exec_rdy0_%0d", i),  rdy[1][0], 64'd0);
        end
        @(negedge clk);
        chk("accept_with_pulse", rdy[1][0], 64'd1);
        chk("accept_cycle", cyc, t + 4);
        tick();
        vld[1][0] = 1'b0;
        repeat (6) tick();

        // Reset in the middle of an ALU_LAT=4 op: nothing comes back, next request still served.
        set_req(2, 0, 4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("pre_reset_result", res[2], 64'd3);
        tick();
        set_req(2, 0, 4'b0000, 32'hF0, 32'hFF, 32'hF0, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        tick();
        rstn[2] = 1'b0;
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].inst == 2) sbq.delete(i);
        @(negedge clk);
        chk_idle_outputs(2, "midreset");
        chk("midreset_result", res[2],  64'd0);
        chk("midreset_zero",   zf[2],   64'd0);
        chk("midreset_rspv",   rspv[2], 64'd0);
        tick();
        rstn[2] = 1'b1;
        repeat (8) tick();
        set_req(2, 0, 4'b0010, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        repeat (6) tick();

`ifdef ALU_ARB_PERF_EN
        // Fresh counters: 3 port-0 grants, 2 port-1 grants, 2 conflict cycles.
        rstn[2] = 1'b0;
        tick();
        rstn[2] = 1'b1;
        set_req(2, 0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        set_req(2, 1, 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        wait_xfer(2, 1, t);
        set_req(2, 0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        wait_xfer(2, 1, t);
        vld[2][1] = 1'b0;
        set_req(2, 0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_xfer(2, 0, t);
        vld[2][0] = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("perf_gnt0",     pg0[2], 64'd3);
        chk("perf_gnt1",     pg1[2], 64'd2);
        chk("perf_conflict", pcf[2], 64'd2);
`endif

        @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
